// File: rtl/router_pkg.sv
// Constants and helpers shared by the three destination FIFOs of the packet router.
// A header byte carries the payload length in [7:2] and the destination address in [1:0].
package router_pkg;

    localparam int DATA_W       = 8;
    localparam int DEPTH        = 16;
    localparam int PTR_W        = $clog2(DEPTH) + 1;
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;
    localparam int CNT_W        = 7;

    typedef logic [CNT_W-1:0]                     pkt_cnt_t;
    typedef logic [HDR_LEN_MSB-HDR_LEN_LSB:0]     hdr_len_t;
    typedef logic [HDR_ADDR_MSB-HDR_ADDR_LSB:0]   hdr_addr_t;

    // Bytes still owed after a header is read: the payload plus one parity byte.
    function automatic pkt_cnt_t pkt_len_load(input hdr_len_t len);
        return pkt_cnt_t'(len) + pkt_cnt_t'(1);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for one router FIFO: one synchronous write port, one combinational read port.
// Contents are intentionally not reset; the pointers decide what is valid.
module router_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W:0]          rdata
);

    logic [DATA_W:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Destination FIFO of the packet router: stores header-tagged bytes and tracks how many
// payload/parity bytes of the packet currently being read are still outstanding.
module router_fifo #(
    parameter int DATA_W = router_pkg::DATA_W,
    parameter int DEPTH  = router_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_active
);

    import router_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    pkt_cnt_t        pkt_cnt;
    logic [DATA_W:0] rd_word;
    logic            wr_acc;
    logic            rd_acc;
    logic            rd_tag;
    hdr_len_t        rd_len;

    // Flags come straight from the pointers so they reflect the state before the edge.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_acc = write_enb && !full;
    assign rd_acc = read_enb && !empty;

    assign rd_tag = rd_word[DATA_W];
    assign rd_len = rd_word[HDR_LEN_MSB:HDR_LEN_LSB];

    assign pkt_active = (pkt_cnt != '0);

    router_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (wr_acc && !soft_reset),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({lfd_state, data_in}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (soft_reset) begin
            wr_ptr <= '0;
        end else if (wr_acc) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (rd_acc) begin
            rd_ptr   <= rd_ptr + PW'(1);
            data_out <= rd_word[DATA_W-1:0];
        end
    end

    // A header reload wins over the countdown; untagged reads past the packet end leave 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_cnt <= '0;
        end else if (soft_reset) begin
            pkt_cnt <= '0;
        end else if (rd_acc) begin
            if (rd_tag) begin
                pkt_cnt <= pkt_len_load(rd_len);
            end else if (pkt_cnt != '0) begin
                pkt_cnt <= pkt_cnt - pkt_cnt_t'(1);
            end
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic       full;
    logic       empty;
    logic [7:0] data_out;
    logic       pkt_active;

    int pass_cnt  = 0;
    int check_cnt = 0;

    router_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out),
        .pkt_active (pkt_active)
    );

    always #5 clock = ~clock;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic hdr);
        write_enb = 1'b1;
        lfd_state = hdr;
        data_in   = b;
        tick();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic pop();
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
        data_in = 8'h00; read_enb = 1'b0;
        tick(); tick();
        check_cnt++;
        if ({full, empty, pkt_active} !== 3'b010) $display("FAIL reset_flags got %b want 010", {full, empty, pkt_active});
        else pass_cnt++;
        check_cnt++;
        if (data_out !== 8'h00) $display("FAIL reset_data got %h want 00", data_out);
        else pass_cnt++;
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic test_packet_write();
        push(8'h0D, 1'b1);
        check_cnt++;
        if (empty !== 1'b0) $display("FAIL wr_first_empty got %b want 0", empty);
        else pass_cnt++;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        check_cnt++;
        if ({full, empty, pkt_active} !== 3'b000) $display("FAIL wr_pkt_flags got %b want 000", {full, empty, pkt_active});
        else pass_cnt++;
    endtask

    task automatic test_packet_read();
        logic [7:0] exp_d [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h44};
        logic       exp_a [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_cnt++;
            if (data_out !== exp_d[i]) $display("FAIL pkt_rd_data[%0d] got %h want %h", i, data_out, exp_d[i]);
            else pass_cnt++;
            check_cnt++;
            if (pkt_active !== exp_a[i]) $display("FAIL pkt_rd_active[%0d] got %b want %b", i, pkt_active, exp_a[i]);
            else pass_cnt++;
        end
        read_enb = 1'b0;
        check_cnt++;
        if (empty !== 1'b1) $display("FAIL pkt_rd_empty got %b want 1", empty);
        else pass_cnt++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            push(8'h40 + 8'(i), 1'b0);
            if (i == 14) begin
                check_cnt++;
                if (full !== 1'b0) $display("FAIL full_at15 got %b want 0", full);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if ({full, empty} !== 2'b10) $display("FAIL full_at16 got %b want 10", {full, empty});
        else pass_cnt++;
        push(8'hEE, 1'b0);
        check_cnt++;
        if (full !== 1'b1) $display("FAIL full_drop17 got %b want 1", full);
        else pass_cnt++;
        write_enb = 1'b1; data_in = 8'hFF; read_enb = 1'b1;
        tick();
        write_enb = 1'b0; read_enb = 1'b0;
        check_cnt++;
        if (data_out !== 8'h40) $display("FAIL full_rw_data got %h want 40", data_out);
        else pass_cnt++;
        check_cnt++;
        if (full !== 1'b0) $display("FAIL full_rw_flag got %b want 0", full);
        else pass_cnt++;
        for (int i = 1; i < 16; i++) begin
            pop();
            check_cnt++;
            if (data_out !== 8'h40 + 8'(i)) $display("FAIL full_drain[%0d] got %h want %h", i, data_out, 8'h40 + 8'(i));
            else pass_cnt++;
        end
        check_cnt++;
        if ({empty, pkt_active} !== 2'b10) $display("FAIL full_drain_end got %b want 10", {empty, pkt_active});
        else pass_cnt++;
        pop();
        check_cnt++;
        if (data_out !== 8'h4F) $display("FAIL empty_read_hold got %h want 4f", data_out);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int wr_n = 0;
        int rd_n = 0;
        for (int i = 0; i < 8; i++) begin
            push(8'(wr_n * 3 + 1), 1'b0);
            wr_n++;
        end
        for (int i = 0; i < 32; i++) begin
            write_enb = 1'b1; data_in = 8'(wr_n * 3 + 1); read_enb = 1'b1;
            tick();
            wr_n++;
            check_cnt++;
            if (data_out !== 8'(rd_n * 3 + 1)) $display("FAIL wrap_data[%0d] got %h want %h", rd_n, data_out, 8'(rd_n * 3 + 1));
            else pass_cnt++;
            rd_n++;
            check_cnt++;
            if ({full, empty} !== 2'b00) $display("FAIL wrap_flags[%0d] got %b want 00", i, {full, empty});
            else pass_cnt++;
        end
        write_enb = 1'b0; read_enb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pop();
            check_cnt++;
            if (data_out !== 8'(rd_n * 3 + 1)) $display("FAIL wrap_tail[%0d] got %h want %h", rd_n, data_out, 8'(rd_n * 3 + 1));
            else pass_cnt++;
            rd_n++;
        end
        check_cnt++;
        if ({full, empty} !== 2'b01) $display("FAIL wrap_end got %b want 01", {full, empty});
        else pass_cnt++;
    endtask

    task automatic test_hdr_bounds();
        push(8'h00, 1'b1);
        push(8'h5A, 1'b0);
        pop();
        check_cnt++;
        if (pkt_active !== 1'b1) $display("FAIL len0_hdr got %b want 1", pkt_active);
        else pass_cnt++;
        pop();
        check_cnt++;
        if ({pkt_active, data_out} !== {1'b0, 8'h5A}) $display("FAIL len0_parity got %h want 05a", {pkt_active, data_out});
        else pass_cnt++;
        // Length 63: header then 64 untagged bytes streamed one in, one out.
        push(8'hFF, 1'b1);
        for (int k = 0; k < 64; k++) begin
            write_enb = 1'b1; data_in = 8'(k); read_enb = 1'b1;
            tick();
            check_cnt++;
            if (pkt_active !== 1'b1) $display("FAIL len63_active[%0d] got %b want 1", k, pkt_active);
            else pass_cnt++;
        end
        write_enb = 1'b0; read_enb = 1'b0;
        check_cnt++;
        if (data_out !== 8'd62) $display("FAIL len63_data got %h want 3e", data_out);
        else pass_cnt++;
        pop();
        check_cnt++;
        if ({pkt_active, empty, data_out} !== {2'b01, 8'd63}) $display("FAIL len63_end got %h want 13f", {pkt_active, empty, data_out});
        else pass_cnt++;
    endtask

    task automatic test_soft_reset();
        push(8'h14, 1'b1);
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 1'b0);
        pop();
        check_cnt++;
        if ({pkt_active, data_out} !== {1'b1, 8'h14}) $display("FAIL srst_pre got %h want 114", {pkt_active, data_out});
        else pass_cnt++;
        soft_reset = 1'b1; read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h99;
        tick();
        soft_reset = 1'b0; read_enb = 1'b0; write_enb = 1'b0;
        check_cnt++;
        if ({full, empty, pkt_active} !== 3'b010) $display("FAIL srst_flags got %b want 010", {full, empty, pkt_active});
        else pass_cnt++;
        check_cnt++;
        if (data_out !== 8'h00) $display("FAIL srst_data got %h want 00", data_out);
        else pass_cnt++;
        push(8'h77, 1'b0);
        pop();
        check_cnt++;
        if ({empty, data_out} !== {1'b1, 8'h77}) $display("FAIL srst_after got %h want 177", {empty, data_out});
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        push(8'h0D, 1'b1);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        pop();
        check_cnt++;
        if ({pkt_active, data_out} !== {1'b1, 8'h0D}) $display("FAIL areset_pre got %h want 10d", {pkt_active, data_out});
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        check_cnt++;
        if ({full, empty, pkt_active} !== 3'b010) $display("FAIL areset_flags got %b want 010", {full, empty, pkt_active});
        else pass_cnt++;
        check_cnt++;
        if (data_out !== 8'h00) $display("FAIL areset_data got %h want 00", data_out);
        else pass_cnt++;
        #1 reset = 1'b0;
        push(8'hA1, 1'b0);
        check_cnt++;
        if (empty !== 1'b0) $display("FAIL areset_wr got %b want 0", empty);
        else pass_cnt++;
        pop();
        check_cnt++;
        if ({empty, data_out} !== {1'b1, 8'hA1}) $display("FAIL areset_rd got %h want 1a1", {empty, data_out});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_packet_write();
        test_packet_read();
        test_full();
        test_wrap();
        test_hdr_bounds();
        test_soft_reset();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 Parameter: DATA_W, 8, payload byte width.
REQ-002 Parameter: DEPTH, 16, entries; power of two.
REQ-003 Port: clock  input  1  single clock, all state rising-edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: soft_reset  input  1  synchronous per-FIFO flush from the synchronizer timeout.
REQ-006 Port: write_enb  input  1  write strobe for this FIFO (one bit of the synchronizer's write_enb[2:0]).
REQ-007 Port: lfd_state  input  1  marks the byte on data_in as a packet header.
REQ-008 Port: data_in  input  DATA_W  byte to store.
REQ-009 Port: read_enb  input  1  read strobe from the destination port.
REQ-010 Port: full  output  1  no free entry.
REQ-011 Port: empty  output  1  no stored entry.
REQ-012 Port: data_out  output  DATA_W  registered read data.
REQ-013 Port: pkt_active  output  1  high while payload/parity bytes of the current packet remain to be read.

Function
REQ-014 Storage: DEPTH entries of DATA_W+1 bits; bit DATA_W holds the header tag.
REQ-015 Pointers: wr_ptr, rd_ptr, each log2(DEPTH)+1 bits; MSB is a wrap bit; increment modulo 2*DEPTH.
REQ-016 empty = (wr_ptr == rd_ptr); full = (low bits equal AND wrap bits differ); both combinational from pointers.
REQ-017 Write accepted when write_enb=1 AND full=0: entry[wr_ptr] <= {lfd_state, data_in}; wr_ptr increments.
REQ-018 write_enb=1 while full=1: write dropped, no state change.
REQ-019 Read accepted when read_enb=1 AND empty=0: data_out <= entry[rd_ptr] low DATA_W bits at the same edge; rd_ptr increments; one-cycle latency from read_enb to data_out.
REQ-020 read_enb=1 while empty=1: ignored; data_out holds.
REQ-021 data_out holds its last value between reads.
REQ-022 Simultaneous accepted read and write: both complete in the same cycle; occupancy unchanged.
REQ-023 When full, a simultaneous write and read: read completes, write dropped (full sampled before the edge).
REQ-024 When empty, a simultaneous write and read: write completes, read ignored.
REQ-025 Packet counter pkt_cnt, 7 bits: on an accepted read of a tagged entry, load header bits [7:2] + 1 (payload length plus parity byte).
REQ-026 On an accepted read of an untagged entry with pkt_cnt != 0, pkt_cnt decrements by 1; at 0 it stays 0.
REQ-027 pkt_active = (pkt_cnt != 0).
REQ-028 Header length 0 loads pkt_cnt=1 (parity only); length 63 loads 64.
REQ-029 soft_reset=1 at a clock edge: pointers, pkt_cnt and data_out cleared to 0; any concurrent read/write in that cycle is discarded; takes priority over all other operations.

Reset
REQ-030 reset=1 asynchronously forces wr_ptr=0, rd_ptr=0, pkt_cnt=0, data_out=0; hence full=0, empty=1, pkt_active=0.
REQ-031 Storage contents need not be cleared by reset or soft_reset.
REQ-032 Reset asserted mid-packet discards all stored bytes; first operation after release behaves as on an empty FIFO.

Structure
REQ-033 Shared package router_pkg holds DATA_W, DEPTH, PTR_W, HDR_LEN_MSB/LSB (7/2) and HDR_ADDR_MSB/LSB (1/0); all three router FIFOs use it.
REQ-034 One sub-module, router_fifo_mem (DEPTH x (DATA_W+1) register array, one write port, one combinational read port); pointer, flag and counter logic remain in router_fifo.

Verification
REQ-035 Reset then write header 0x0D (len 3, addr 1) with lfd_state=1, bytes 0x11,0x22,0x33, parity 0x44 -> empty=0 after first write; four pointers advance; full=0.
REQ-036 Read those 5 bytes back-to-back -> data_out 0x0D,0x11,0x22,0x33,0x44 one cycle after each read_enb; pkt_active=1 from the header read until the parity read, then 0; empty=1.
REQ-037 Write 16 bytes -> full=1 after 16th; 17th write dropped; simultaneous read+write at full -> one byte out, full drops to 0, write lost.
REQ-038 Fill/drain 40 bytes with 8 entries in flight -> pointers wrap past 16 with no corruption; flags correct at each wrap.
REQ-039 soft_reset pulse with 6 bytes stored and read_enb=1 -> next cycle empty=1, data_out=0, pkt_active=0, read discarded.
REQ-040 Assert reset asynchronously between clock edges mid-packet -> outputs reach reset values before the next edge.
